mem_access_stage: RTL and testbench

- MEM stage plus MEM/WB pipeline register.
- Consumes the EX/MEM register outputs and drives a variable-latency data-memory port using a req/ack handshake.
- Performs byte-lane alignment, sign or zero extension and write-back source selection.
- Asserts stall_o upstream while a memory access is outstanding.

---
 rtl/mem_access_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB pipeline register. Drives a variable-latency req/ack data-memory port,
// aligns store lanes, extracts and extends load data, and stalls upstream while an access is open.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] advance_pc_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] reg_2_data_i,
   input  logic [4:0]  rd_i,
   input  logic        reg_write_i,
   input  logic [1:0]  mem_width_i,
   input  logic        mem_sign_extend_i,
   input  logic [1:0]  reg_src_i,
   input  logic        mem_write_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        wb_valid_o,
   output logic        wb_reg_write_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;

   // Snapshot of the instruction in flight, used to build the write-back on ack.
   logic [4:0]  m_rd_q, m_rd_d;
   logic        m_rw_q, m_rw_d;
   logic [1:0]  m_width_q, m_width_d;
   logic        m_sign_q, m_sign_d;
   logic [1:0]  m_off_q, m_off_d;
   logic [1:0]  m_src_q, m_src_d;
   logic [31:0] m_alt_q, m_alt_d;

   logic        wb_valid_q, wb_valid_d;
   logic        wb_rw_q, wb_rw_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        access, misaligned, start, timeout;
   logic [3:0]  be_lanes;
   logic [31:0] wdata_lanes, alt_data, shifted, load_data;

   assign access  = valid_i & (mem_write_i | (reg_src_i == 2'b01));
   assign start   = (state_q == StIdle) & access & ~misaligned;
   assign timeout = (state_q == StWait) & ~dmem_ack_i & (cnt_q == TimeoutLast);

   always_comb begin
      unique case (mem_width_i)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = alu_result_i[0];
         default: misaligned = |alu_result_i[1:0];
      endcase
   end

   always_comb begin
      unique case (mem_width_i)
         2'b00: begin
            be_lanes    = 4'b0001 << alu_result_i[1:0];
            wdata_lanes = {4{reg_2_data_i[7:0]}};
         end
         2'b01: begin
            be_lanes    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{reg_2_data_i[15:0]}};
         end
         default: begin
            be_lanes    = 4'b1111;
            wdata_lanes = reg_2_data_i;
         end
      endcase
   end

   // Non-memory write-back source; the memory source is resolved on ack.
   always_comb begin
      unique case (reg_src_i)
         2'b00:   alt_data = alu_result_i;
         2'b10:   alt_data = advance_pc_i;
         default: alt_data = 32'h0;
      endcase
   end

   assign shifted = dmem_rdata_i >> {m_off_q, 3'b000};

   always_comb begin
      unique case (m_width_q)
         2'b00:   load_data = {{24{m_sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{16{m_sign_q & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StWait;
         StWait: if (dmem_ack_i || timeout) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      stall_o = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StIdle:  stall_o = start;
            StWait:  stall_o = ~dmem_ack_i;
            default: stall_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      m_rd_d     = m_rd_q;
      m_rw_d     = m_rw_q;
      m_width_d  = m_width_q;
      m_sign_d   = m_sign_q;
      m_off_d    = m_off_q;
      m_src_d    = m_src_q;
      m_alt_d    = m_alt_q;
      wb_valid_d = wb_valid_q;
      wb_rw_d    = wb_rw_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d      = '0;
               req_d      = 1'b1;
               we_d       = mem_write_i;
               addr_d     = {alu_result_i[31:2], 2'b00};
               be_d       = be_lanes;
               wdata_d    = wdata_lanes;
               m_rd_d     = rd_i;
               m_rw_d     = reg_write_i;
               m_width_d  = mem_width_i;
               m_sign_d   = mem_sign_extend_i;
               m_off_d    = alu_result_i[1:0];
               m_src_d    = reg_src_i;
               m_alt_d    = alt_data;
               wb_valid_d = 1'b0;
               wb_rw_d    = 1'b0;
            end else if (access) begin
               misalign_d = 1'b1;
               wb_valid_d = 1'b0;
               wb_rw_d    = 1'b0;
            end else begin
               wb_valid_d = valid_i;
               wb_rw_d    = valid_i & reg_write_i;
               wb_rd_d    = rd_i;
               wb_data_d  = alt_data;
            end
         end
         StWait: begin
            if (dmem_ack_i) begin
               req_d      = 1'b0;
               we_d       = 1'b0;
               wb_valid_d = 1'b1;
               wb_rw_d    = m_rw_q;
               wb_rd_d    = m_rd_q;
               wb_data_d  = (m_src_q == 2'b01) ? load_data : m_alt_q;
            end else if (timeout) begin
               req_d      = 1'b0;
               we_d       = 1'b0;
               bus_err_d  = 1'b1;
               wb_valid_d = 1'b0;
               wb_rw_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         m_rd_q     <= '0;
         m_rw_q     <= 1'b0;
         m_width_q  <= '0;
         m_sign_q   <= 1'b0;
         m_off_q    <= '0;
         m_src_q    <= '0;
         m_alt_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         m_rd_q     <= m_rd_d;
         m_rw_q     <= m_rw_d;
         m_width_q  <= m_width_d;
         m_sign_q   <= m_sign_d;
         m_off_q    <= m_off_d;
         m_src_q    <= m_src_d;
         m_alt_q    <= m_alt_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign dmem_req_o     = req_q;
   assign dmem_we_o      = we_q;
   assign dmem_addr_o    = addr_q;
   assign dmem_be_o      = be_q;
   assign dmem_wdata_o   = wdata_q;
   assign wb_valid_o     = wb_valid_q;
   assign wb_reg_write_o = wb_rw_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_data_o      = wb_data_q;
   assign misalign_o     = misalign_q;
   assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, handshake corner sequences and random
// instructions checked against an arithmetic reference model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [31:0] advance_pc_i;
   logic [31:0] alu_result_i;
   logic [31:0] reg_2_data_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic [1:0]  mem_width_i;
   logic        mem_sign_extend_i;
   logic [1:0]  reg_src_i;
   logic        mem_write_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        wb_valid_o;
   logic        wb_reg_write_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        misalign_o;
   logic        bus_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .valid_i           (valid_i),
      .advance_pc_i      (advance_pc_i),
      .alu_result_i      (alu_result_i),
      .reg_2_data_i      (reg_2_data_i),
      .rd_i              (rd_i),
      .reg_write_i       (reg_write_i),
      .mem_width_i       (mem_width_i),
      .mem_sign_extend_i (mem_sign_extend_i),
      .reg_src_i         (reg_src_i),
      .mem_write_i       (mem_write_i),
      .stall_o           (stall_o),
      .dmem_req_o        (dmem_req_o),
      .dmem_we_o         (dmem_we_o),
      .dmem_addr_o       (dmem_addr_o),
      .dmem_be_o         (dmem_be_o),
      .dmem_wdata_o      (dmem_wdata_o),
      .dmem_ack_i        (dmem_ack_i),
      .dmem_rdata_i      (dmem_rdata_i),
      .wb_valid_o        (wb_valid_o),
      .wb_reg_write_o    (wb_reg_write_o),
      .wb_rd_o           (wb_rd_o),
      .wb_data_o         (wb_data_o),
      .misalign_o        (misalign_o),
      .bus_err_o         (bus_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [1:0]  w;
      logic        s;
      logic [1:0]  src;
      logic        wr;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] pc;
      logic [31:0] rdat;
      int          dly;
      logic        ereq;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic        emis;
      logic        ewbv;
      logic        ewbw;
      logic [31:0] ewbd;
   } vec_t;

   function automatic vec_t mk(logic vld, logic [1:0] w, logic s, logic [1:0] src, logic wr,
                               logic rw, logic [4:0] rd, logic [31:0] a, logic [31:0] d,
                               logic [31:0] pc, logic [31:0] rdat, int dly, logic ereq,
                               logic [3:0] ebe, logic [31:0] ewd, logic emis, logic ewbv,
                               logic ewbw, logic [31:0] ewbd);
      vec_t v;
      v.vld = vld; v.w = w; v.s = s; v.src = src; v.wr = wr; v.rw = rw; v.rd = rd;
      v.a = a; v.d = d; v.pc = pc; v.rdat = rdat; v.dly = dly; v.ereq = ereq; v.ebe = ebe;
      v.ewd = ewd; v.emis = emis; v.ewbv = ewbv; v.ewbw = ewbw; v.ewbd = ewbd;
      return v;
   endfunction

   // Reference model: expected results from the access rules with plain arithmetic.
   function automatic vec_t model(vec_t vin);
      vec_t        v = vin;
      int          nb, off;
      logic        acc;
      logic [31:0] mask, ld;
      nb   = (v.w == 2'd0) ? 1 : (v.w == 2'd1) ? 2 : 4;
      off  = int'(v.a % 4);
      acc  = v.vld && (v.wr || v.src == 2'b01);
      v.emis = acc && (v.a % nb != 0);
      v.ereq = acc && !v.emis;
      v.ebe  = 4'(((1 << nb) - 1) << off);
      for (int k = 0; k < 4; k++) v.ewd[8*k +: 8] = v.d[8*(k % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
      ld   = (v.rdat >> (8 * off)) & mask;
      if (v.s && ld[8*nb-1]) ld = ld | ~mask;
      v.ewbv = v.emis ? 1'b0 : v.vld;
      v.ewbw = v.emis ? 1'b0 : (v.vld && v.rw);
      case (v.src)
         2'd0:    v.ewbd = v.a;
         2'd1:    v.ewbd = ld;
         2'd2:    v.ewbd = v.pc;
         default: v.ewbd = 32'h0;
      endcase
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input vec_t v);
      valid_i = v.vld; mem_width_i = v.w; mem_sign_extend_i = v.s; reg_src_i = v.src;
      mem_write_i = v.wr; reg_write_i = v.rw; rd_i = v.rd; alu_result_i = v.a;
      reg_2_data_i = v.d; advance_pc_i = v.pc; dmem_ack_i = 1'b0;
      @(negedge clk);
      chk("stall_issue", stall_o, v.ereq);
      chk("req_idle", dmem_req_o, 0);
      tick();
      if (v.ereq) begin
         chk("req_on", dmem_req_o, 1);
         chk("we", dmem_we_o, v.wr);
         chk("addr", dmem_addr_o, {v.a[31:2], 2'b00});
         chk("bubble", wb_valid_o, 0);
         if (v.wr) begin
            chk("be", dmem_be_o, v.ebe);
            chk("wdata", dmem_wdata_o, v.ewd);
         end
         for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            chk("stall_wait", stall_o, 1);
            chk("req_hold", dmem_req_o, 1);
            chk("wb_idle_wait", wb_valid_o, 0);
            tick();
         end
         dmem_ack_i = 1'b1;
         dmem_rdata_i = v.rdat;
         @(negedge clk);
         chk("stall_ack", stall_o, 0);
         tick();
         dmem_ack_i = 1'b0;
         valid_i = 1'b0;
         chk("req_off", dmem_req_o, 0);
         chk("bus_err_ack", bus_err_o, 0);
      end else begin
         chk("req_none", dmem_req_o, 0);
         chk("misalign", misalign_o, v.emis);
      end
      chk("wb_valid", wb_valid_o, v.ewbv);
      chk("wb_reg_write", wb_reg_write_o, v.ewbw);
      if (v.ewbv) begin
         chk("wb_rd", wb_rd_o, v.rd);
         chk("wb_data", wb_data_o, v.ewbd);
      end
   endtask

   vec_t tbl[14];
   vec_t rv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1, 2'b10, 0, 2'b00, 0, 1, 5, 32'h1234, 0, 32'h8, 0, 0,
                   0, 0, 0, 0, 1, 1, 32'h1234);
      tbl[1]  = mk(1, 2'b00, 1, 2'b01, 0, 1, 7, 32'h103, 0, 0, 32'h80AABBCC, 0,
                   1, 4'b1000, 0, 0, 1, 1, 32'hFFFFFF80);
      tbl[2]  = mk(1, 2'b01, 0, 2'b01, 0, 1, 8, 32'h102, 0, 0, 32'h8001FFFF, 3,
                   1, 4'b1100, 0, 0, 1, 1, 32'h00008001);
      tbl[3]  = mk(1, 2'b00, 0, 2'b00, 1, 0, 0, 32'h201, 32'hA5, 0, 0, 1,
                   1, 4'b0010, 32'hA5A5A5A5, 0, 1, 0, 32'h201);
      tbl[4]  = mk(1, 2'b10, 0, 2'b01, 0, 1, 9, 32'h102, 0, 0, 0, 0,
                   0, 0, 0, 1, 0, 0, 0);
      tbl[5]  = mk(1, 2'b10, 0, 2'b10, 0, 1, 1, 32'hFFFF0000, 0, 32'h44, 0, 0,
                   0, 0, 0, 0, 1, 1, 32'h44);
      tbl[6]  = mk(1, 2'b00, 0, 2'b11, 0, 1, 2, 32'h55, 0, 32'h9, 0, 0,
                   0, 0, 0, 0, 1, 1, 32'h0);
      tbl[7]  = mk(0, 2'b10, 0, 2'b01, 1, 1, 3, 32'h700, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 2'b01, 0, 2'b00, 1, 0, 4, 32'h302, 32'h1234BEEF, 0, 0, 1,
                   1, 4'b1100, 32'hBEEFBEEF, 0, 1, 0, 32'h302);
      tbl[9]  = mk(1, 2'b01, 1, 2'b01, 0, 1, 10, 32'h200, 0, 0, 32'h0000F00D, 2,
                   1, 4'b0011, 0, 0, 1, 1, 32'hFFFFF00D);
      tbl[10] = mk(1, 2'b11, 1, 2'b01, 0, 1, 11, 32'h400, 0, 0, 32'hDEADBEEF, 0,
                   1, 4'b1111, 0, 0, 1, 1, 32'hDEADBEEF);
      tbl[11] = mk(1, 2'b01, 0, 2'b00, 1, 0, 12, 32'h101, 32'h77, 0, 0, 0,
                   0, 0, 0, 1, 0, 0, 0);
      tbl[12] = mk(1, 2'b00, 0, 2'b01, 0, 1, 13, 32'h101, 0, 0, 32'h123480FF, 1,
                   1, 4'b0010, 0, 0, 1, 1, 32'h00000080);
      tbl[13] = mk(1, 2'b10, 0, 2'b00, 1, 0, 14, 32'h800, 32'hCAFEF00D, 0, 0, 2,
                   1, 4'b1111, 32'hCAFEF00D, 0, 1, 0, 32'h800);

      rst = 1'b1; valid_i = 1'b0; advance_pc_i = '0; alu_result_i = '0; reg_2_data_i = '0;
      rd_i = '0; reg_write_i = 1'b0; mem_width_i = '0; mem_sign_extend_i = 1'b0;
      reg_src_i = '0; mem_write_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      tick();
      tick();
      chk("rst_req", dmem_req_o, 0);
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_wb_data", wb_data_o, 0);
      chk("rst_flags", {misalign_o, bus_err_o, wb_reg_write_o}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", stall_o, 0);
      tick();

      for (int i = 0; i < 14; i++) run_instr(tbl[i]);

      // Timeout: store never acked, TIMEOUT_CYCLES = 4.
      run_timeout();

      // Reset while waiting; a late ack must not produce a write-back.
      valid_i = 1'b1; mem_width_i = 2'b10; reg_src_i = 2'b01; mem_write_i = 1'b0;
      reg_write_i = 1'b1; rd_i = 5'd20; alu_result_i = 32'h600; dmem_ack_i = 1'b0;
      tick();
      @(negedge clk);
      chk("pre_rst_req", dmem_req_o, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      valid_i = 1'b0;
      chk("rstw_req", dmem_req_o, 0);
      chk("rstw_we_addr", {31'd0, dmem_we_o} | dmem_addr_o, 0);
      chk("rstw_be_wdata", {28'd0, dmem_be_o} | dmem_wdata_o, 0);
      chk("rstw_wb", {wb_valid_o, wb_reg_write_o, wb_rd_o, misalign_o, bus_err_o}, 0);
      chk("rstw_wb_data", wb_data_o, 0);
      @(negedge clk);
      chk("rstw_stall", stall_o, 0);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h13579BDF;
      tick();
      dmem_ack_i = 1'b0;
      chk("late_ack_wb", wb_valid_o, 0);
      chk("late_ack_req", dmem_req_o, 0);
      tick();
      chk("late_ack_wb2", wb_valid_o | wb_reg_write_o, 0);

      // Random instructions against the reference model.
      for (int i = 0; i < 80; i++) begin
         rv.vld  = ($urandom_range(0, 7) != 0);
         rv.w    = 2'($urandom_range(0, 3));
         rv.s    = 1'($urandom_range(0, 1));
         rv.src  = 2'($urandom_range(0, 3));
         rv.wr   = 1'($urandom_range(0, 1));
         rv.rw   = 1'($urandom_range(0, 1));
         rv.rd   = 5'($urandom);
         rv.a    = $urandom;
         if ($urandom_range(0, 1) == 0) rv.a[1:0] = 2'b00;
         rv.d    = $urandom;
         rv.pc   = $urandom;
         rv.rdat = $urandom;
         rv.dly  = $urandom_range(0, 3);
         run_instr(model(rv));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic run_timeout();
      valid_i = 1'b1; mem_width_i = 2'b10; reg_src_i = 2'b00; mem_write_i = 1'b1;
      reg_write_i = 1'b0; rd_i = 5'd0; alu_result_i = 32'h500; reg_2_data_i = 32'h600DF00D;
      dmem_ack_i = 1'b0;
      @(negedge clk);
      chk("to_stall_issue", stall_o, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_req_held", dmem_req_o, 1);
         chk("to_stall", stall_o, 1);
         chk("to_no_err_yet", bus_err_o, 0);
         tick();
      end
      valid_i = 1'b0;
      chk("to_req_drop", dmem_req_o, 0);
      chk("to_bus_err", bus_err_o, 1);
      chk("to_misalign", misalign_o, 0);
      chk("to_wb", {wb_valid_o, wb_reg_write_o}, 0);
      @(negedge clk);
      chk("to_stall_rel", stall_o, 0);
      tick();
      chk("to_err_pulse", bus_err_o, 0);
   endtask

endmodule
